// File: rtl/ro_fa_cache_pkg.sv
// Shared constants for the read-only fully associative cache.
// The tag is the word address: byte-offset bits below TAG_LSB are ignored.
package ro_fa_cache_pkg;

   localparam int W_ADDR_DEF    = 32;
   localparam int W_DATA_DEF    = 32;
   localparam int N_ENTRIES_DEF = 8;
   localparam int TAG_LSB       = 2;

endpackage

// File: rtl/ro_fa_cache_entry.sv
// One cache line: valid/tag/data storage with a lookup compare and a fill compare.
// Only the valid bit is reset; tag and data are qualified by it.
module ro_fa_cache_entry
   import ro_fa_cache_pkg::*;
#(
   parameter int W_TAG  = W_ADDR_DEF - TAG_LSB,
   parameter int W_DATA = W_DATA_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [W_TAG-1:0]  tag_i,
   input  logic [W_DATA-1:0] data_i,
   input  logic [W_TAG-1:0]  rtag_i,
   input  logic [W_TAG-1:0]  wtag_i,
   output logic              hit_o,
   output logic              whit_o,
   output logic [W_DATA-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [W_TAG-1:0]  tag_q;
   logic [W_DATA-1:0] data_q;

   always_comb begin
      valid_d = valid_q;
      if (load_i) begin
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (load_i) begin
         tag_q  <= tag_i;
         data_q <= data_i;
      end
   end

   assign hit_o  = valid_q && (tag_q == rtag_i);
   assign whit_o = valid_q && (tag_q == wtag_i);
   assign data_o = data_q;

endmodule

// File: rtl/ro_fa_cache.sv
// Read-only fully associative word cache with FIFO replacement.
// Hit is combinational on raddr; data for that lookup is registered one cycle later.
module ro_fa_cache
   import ro_fa_cache_pkg::*;
#(
   parameter int W_DATA    = W_DATA_DEF,
   parameter int W_ADDR    = W_ADDR_DEF,
   parameter int N_ENTRIES = N_ENTRIES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W_ADDR-1:0] raddr,
   output logic [W_DATA-1:0] rdata,
   output logic              rvalid,
   input  logic [W_ADDR-1:0] waddr,
   input  logic [W_DATA-1:0] wdata,
   input  logic              wen
);

   localparam int W_TAG = W_ADDR - TAG_LSB;
   localparam int W_PTR = $clog2(N_ENTRIES);

   logic [W_TAG-1:0]  rtag, wtag;
   logic [N_ENTRIES-1:0] hit, whit, load;
   logic [W_DATA-1:0] edata [N_ENTRIES];
   logic              any_whit;
   logic [W_PTR-1:0]  ptr_q, ptr_d;
   logic [W_DATA-1:0] rdata_q, rdata_d;
   logic              unused_lsbs;

   assign rtag        = raddr[W_ADDR-1:TAG_LSB];
   assign wtag        = waddr[W_ADDR-1:TAG_LSB];
   assign unused_lsbs = ^{raddr[TAG_LSB-1:0], waddr[TAG_LSB-1:0]};

   for (genvar g = 0; g < N_ENTRIES; g++) begin : g_entry
      ro_fa_cache_entry #(
         .W_TAG  (W_TAG),
         .W_DATA (W_DATA)
      ) u_entry (
         .clk_i  (clk),
         .rst_i  (rst),
         .load_i (load[g]),
         .tag_i  (wtag),
         .data_i (wdata),
         .rtag_i (rtag),
         .wtag_i (wtag),
         .hit_o  (hit[g]),
         .whit_o (whit[g]),
         .data_o (edata[g])
      );
   end

   assign any_whit = |whit;

   // A fill to a resident tag updates in place; otherwise the FIFO slot at ptr is taken.
   always_comb begin
      load = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         if (wen) begin
            load[i] = any_whit ? whit[i] : (ptr_q == W_PTR'(i));
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (wen && !any_whit) begin
         ptr_d = ptr_q + W_PTR'(1);
      end
   end

   // Tags are unique, so at most one hit bit is set and an AND-OR mux suffices.
   always_comb begin
      rdata_d = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         rdata_d = rdata_d | (edata[i] & {W_DATA{hit[i]}});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         rdata_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         rdata_q <= rdata_d;
      end
   end

   assign rvalid = |hit;
   assign rdata  = rdata_q;

endmodule

// File: tb/tb_ro_fa_cache.sv
// Scoreboard bench for ro_fa_cache: a FIFO-queue reference model predicts each lookup,
// a negedge monitor checks rvalid in the lookup cycle and rdata one cycle later.
module tb_ro_fa_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] raddr, rdata, waddr, wdata;
   logic        rvalid, wen;

   always #5 clk = ~clk;

   ro_fa_cache dut (
      .clk    (clk),
      .rst    (rst),
      .raddr  (raddr),
      .rdata  (rdata),
      .rvalid (rvalid),
      .waddr  (waddr),
      .wdata  (wdata),
      .wen    (wen)
   );

   typedef struct {
      logic [29:0] tag;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      bit          rv;
      logic [31:0] rd;
      int          id;
   } exp_t;

   ent_t model[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 0;
   int   step_no = 0;

   function automatic int find_tag(logic [29:0] t);
      foreach (model[i]) if (model[i].tag == t) return i;
      return -1;
   endfunction

   task automatic step(bit r, logic [31:0] ra, bit we, logic [31:0] wa, logic [31:0] wd);
      exp_t e;
      ent_t n;
      int   h;
      @(posedge clk);
      #1;
      rst = r; raddr = ra; wen = we; waddr = wa; wdata = wd;
      h = find_tag(ra[31:2]);
      e.rv = (h >= 0);
      e.rd = (r || h < 0) ? 32'h0 : model[h].data;
      e.id = step_no;
      step_no++;
      sb.push_back(e);
      if (r) begin
         model.delete();
      end else if (we) begin
         h = find_tag(wa[31:2]);
         if (h >= 0) begin
            model[h].data = wd;
         end else begin
            if (model.size() == 8) void'(model.pop_front());
            n.tag = wa[31:2];
            n.data = wd;
            model.push_back(n);
         end
      end
   endtask

   task automatic rd(logic [31:0] a);
      step(0, a, 0, 32'h0, 32'h0);
   endtask

   task automatic fill(logic [31:0] a, logic [31:0] d);
      step(0, 32'hFFFF_FFF0, 1, a, d);
   endtask

   // Monitor
   initial begin
      exp_t e, pend;
      bit   have = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (have) begin
               checks++;
               if (rdata !== pend.rd) begin
                  errors++;
                  $display("FAIL rdata step %0d: got %h want %h", pend.id, rdata, pend.rd);
               end
            end
            if (sb.size() > 0) begin
               e = sb.pop_front();
               checks++;
               if (rvalid !== e.rv) begin
                  errors++;
                  $display("FAIL rvalid step %0d: got %b want %b", e.id, rvalid, e.rv);
               end
               pend = e;
               have = 1;
            end else begin
               have = 0;
            end
         end
      end
   end

   initial begin
      rst = 1; raddr = 0; wen = 0; waddr = 0; wdata = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_rvalid: got %b want 0", rvalid);
      end
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata: got %h want 0", rdata);
      end
      mon_en = 1;

      // 1: misses after reset
      rd(32'h0000_0000);
      rd(32'h1000_0004);
      // 2: fill then hit with ignored byte offset
      fill(32'h100, 32'hDEAD_BEEF);
      rd(32'h102);
      rd(32'h0);
      // 3: same-cycle fill and lookup sees pre-write state
      step(1, 32'h0, 0, 32'h0, 32'h0);
      step(0, 32'h100, 1, 32'h100, 32'hCAFE_F00D);
      rd(32'h100);
      // 4: nine fills wrap the FIFO
      step(1, 32'h0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 9; i++) fill(32'(i * 4), 32'(i * 4));
      for (int i = 0; i < 9; i++) rd(32'(i * 4));
      fill(32'h40, 32'h40);
      rd(32'h4);
      rd(32'h8);
      rd(32'h40);
      // 5: in-place update consumes one entry
      step(1, 32'h0, 0, 32'h0, 32'h0);
      fill(32'h8, 32'h1111);
      fill(32'h8, 32'h2222);
      rd(32'h8);
      for (int i = 0; i < 7; i++) fill(32'h300 + 32'(i * 4), 32'hA000 + 32'(i));
      rd(32'h8);
      fill(32'h400, 32'hB000);
      rd(32'h8);
      rd(32'h400);
      // 6: reset with full cache and a concurrent fill
      for (int i = 0; i < 8; i++) fill(32'h500 + 32'(i * 4), 32'hC000 + 32'(i));
      step(1, 32'h504, 1, 32'h600, 32'h1234_5678);
      for (int i = 0; i < 8; i++) rd(32'h500 + 32'(i * 4));
      rd(32'h600);

      // Randomized traffic over a small address pool to mix hits, misses and evictions
      for (int n = 0; n < 400; n++) begin
         logic [31:0] ra, wa;
         ra = {24'h0, 4'($urandom_range(0, 15)), 2'b00} | 32'($urandom_range(0, 3));
         wa = {24'h0, 4'($urandom_range(0, 15)), 2'b00} | 32'($urandom_range(0, 3));
         step(($urandom_range(0, 63) == 0), ra, ($urandom_range(0, 1) == 1), wa, $urandom);
      end

      @(posedge clk);
      #1 wen = 0; rst = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
